// File: rtl/nios2_mul_pkg.sv
// Shared definitions for the Nios II multiply sequencer: op encodings, FSM
// states and the half-word rotate used to launch the high-word pass.
package nios2_mul_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'd0,
        OP_MULXUU = 2'd1,
        OP_MULXSU = 2'd2,
        OP_MULXSS = 2'd3
    } mul_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_P0   = 2'd1,
        ST_P1   = 2'd2
    } mul_state_e;

    function automatic logic [31:0] rot16(input logic [31:0] v);
        return {v[15:0], v[31:16]};
    endfunction

endpackage

// File: rtl/nios2_mul_cell.sv
// CPU mult cell: three registered 16x16 unsigned partial products,
// one-cycle latency, updated only while enabled.
module nios2_mul_cell (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] p1,
    output logic [31:0] p2,
    output logic [31:0] p3
);

    logic [31:0] p1_q;
    logic [31:0] p2_q;
    logic [31:0] p3_q;

    // Partial product registers: lo*lo, lo*hi, hi*lo
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p1_q <= 32'd0;
            p2_q <= 32'd0;
            p3_q <= 32'd0;
        end else if (en) begin
            p1_q <= {16'd0, a[15:0]}  * {16'd0, b[15:0]};
            p2_q <= {16'd0, a[15:0]}  * {16'd0, b[31:16]};
            p3_q <= {16'd0, a[31:16]} * {16'd0, b[15:0]};
        end
    end

    assign p1 = p1_q;
    assign p2 = p2_q;
    assign p3 = p3_q;

endmodule

// File: rtl/nios2_mul_sequencer.sv
// Multiply sequencer: one cell pass for MUL, a second rotated-operand pass
// for the MULX* high word with signed correction.
module nios2_mul_sequencer
    import nios2_mul_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] E_src1,
    input  logic [31:0] E_src2,
    output logic        busy,
    output logic        result_valid,
    output logic [31:0] result
);

    mul_state_e  state_q, state_d;
    mul_op_e     op_q;
    logic [31:0] a_q, b_q;
    logic [63:0] s_q;
    logic [31:0] result_q;
    logic        result_valid_q;

    logic        cell_en_s;
    logic [31:0] cell_a_s, cell_b_s;
    logic [31:0] p1_s, p2_s, p3_s;
    logic        latch_s;
    logic [32:0] mid_s;
    logic [63:0] prod_lo_s;
    logic [31:0] corr_a_s, corr_b_s, hi_s;
    logic        s_lo_unused_s;

    nios2_mul_cell u_cell (
        .clk     (clk),
        .reset_n (~reset),
        .en      (cell_en_s),
        .a       (cell_a_s),
        .b       (cell_b_s),
        .p1      (p1_s),
        .p2      (p2_s),
        .p3      (p3_s)
    );

    assign latch_s = (state_q == ST_IDLE) && start;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: state_d = start ? ST_P0 : ST_IDLE;
            ST_P0:   state_d = (op_q == OP_MUL) ? ST_IDLE : ST_P1;
            ST_P1:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Cell launch: fresh operands in IDLE, rotated latched operands in P0
    always_comb begin
        cell_en_s = 1'b0;
        cell_a_s  = E_src1;
        cell_b_s  = E_src2;
        case (state_q)
            ST_IDLE: cell_en_s = start;
            ST_P0: begin
                cell_en_s = (op_q != OP_MUL);
                cell_a_s  = rot16(a_q);
                cell_b_s  = rot16(b_q);
            end
            default: cell_en_s = 1'b0;
        endcase
    end

    // M1+M2 can carry into bit 32; keep it so S is the exact low 64-bit partial sum
    assign mid_s     = {1'b0, p2_s} + {1'b0, p3_s};
    assign prod_lo_s = {32'd0, p1_s} + {15'd0, mid_s, 16'd0};

    // Signed high word = unsigned high word minus the sign-weighted opposite operand
    assign corr_b_s = (((op_q == OP_MULXSU) || (op_q == OP_MULXSS)) && a_q[31]) ? b_q : 32'd0;
    assign corr_a_s = ((op_q == OP_MULXSS) && b_q[31]) ? a_q : 32'd0;
    assign hi_s     = p1_s + s_q[63:32] - corr_b_s - corr_a_s;

    assign s_lo_unused_s = ^s_q[31:0];

    // Operand capture and partial-sum register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q  <= 32'd0;
            b_q  <= 32'd0;
            op_q <= OP_MUL;
            s_q  <= 64'd0;
        end else begin
            if (latch_s) begin
                a_q  <= E_src1;
                b_q  <= E_src2;
                op_q <= mul_op_e'(op);
            end
            if ((state_q == ST_P0) && (op_q != OP_MUL)) begin
                s_q <= prod_lo_s;
            end
        end
    end

    // Result register and completion pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q       <= 32'd0;
            result_valid_q <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            case (state_q)
                ST_P0: begin
                    if (op_q == OP_MUL) begin
                        result_q       <= prod_lo_s[31:0];
                        result_valid_q <= 1'b1;
                    end
                end
                ST_P1: begin
                    result_q       <= hi_s;
                    result_valid_q <= 1'b1;
                end
                default: result_valid_q <= 1'b0;
            endcase
        end
    end

    assign busy         = (state_q != ST_IDLE);
    assign result_valid = result_valid_q;
    assign result       = result_q;

endmodule

// File: tb/tb_nios2_mul_sequencer.sv
// Self-checking bench for nios2_mul_sequencer against a 64-bit arithmetic model.
module tb_nios2_mul_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] e_src1 = 32'd0;
    logic [31:0] e_src2 = 32'd0;
    logic        busy;
    logic        result_valid;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;

    nios2_mul_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .op           (op),
        .E_src1       (e_src1),
        .E_src2       (e_src2),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result)
    );

    always #5 clk = ~clk;

    // Reference: sign/zero-extend to 64 bits and take the selected word
    function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (((o == 2'd2) || (o == 2'd3)) && a[31]) ? {32'hFFFF_FFFF, a} : {32'd0, a};
        eb = ((o == 2'd3) && b[31]) ? {32'hFFFF_FFFF, b} : {32'd0, b};
        p  = ea * eb;
        return (o == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    function automatic int exp_lat(input logic [1:0] o);
        return (o == 2'd0) ? 2 : 3;
    endfunction

    // Issue one op at the current negedge; report result, latency and busy-cycle count
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int busy_cnt);
        start = 1'b1; op = o; e_src1 = a; e_src2 = b;
        lat = 0; busy_cnt = 0; res = 32'hDEAD_BEEF;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (result_valid) begin
                lat = c;
                res = result;
                break;
            end
            if (busy) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0 || result !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b rv=%b result=%h expected 0 0 00000000", busy, result_valid, result);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [1:0]  ops [6] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3};
        logic [31:0] as  [6] = '{32'h0001_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] bs  [6] = '{32'h0002_0005, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0002, 32'h0000_0002, 32'h8000_0000};
        logic [31:0] exp [6] = '{32'h000B_000F, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h4000_0000};
        logic [31:0] res;
        int lat, bc;
        for (int i = 0; i < 6; i++) begin
            run_op(ops[i], as[i], bs[i], res, lat, bc);
            checks++;
            if (res !== exp[i]) begin
                errors++;
                $display("FAIL directed_%0d_result: got %h expected %h", i, res, exp[i]);
            end
            checks++;
            if (lat != exp_lat(ops[i]) || bc != exp_lat(ops[i]) - 1) begin
                errors++;
                $display("FAIL directed_%0d_timing: latency=%0d busy=%0d expected %0d %0d",
                         i, lat, bc, exp_lat(ops[i]), exp_lat(ops[i]) - 1);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        int lat, bc;
        run_op(2'd0, 32'h1234_5678, 32'h9ABC_DEF0, res, lat, bc);
        checks++;
        if (res !== ref_mul(2'd0, 32'h1234_5678, 32'h9ABC_DEF0) || lat != 2) begin
            errors++;
            $display("FAIL b2b_first: got %h lat=%0d expected %h lat=2", res, lat, ref_mul(2'd0, 32'h1234_5678, 32'h9ABC_DEF0));
        end
        run_op(2'd3, 32'hF00F_1234, 32'h8765_4321, res, lat, bc);
        checks++;
        if (res !== ref_mul(2'd3, 32'hF00F_1234, 32'h8765_4321) || lat != 3) begin
            errors++;
            $display("FAIL b2b_second: got %h lat=%0d expected %h lat=3", res, lat, ref_mul(2'd3, 32'hF00F_1234, 32'h8765_4321));
        end
        @(negedge clk);
    endtask

    task automatic test_busy_ignore();
        int pulses = 0;
        logic [31:0] got = 32'd0;
        start = 1'b1; op = 2'd1; e_src1 = 32'hCAFE_F00D; e_src2 = 32'h1357_9BDF;
        @(negedge clk);
        start = 1'b1; op = 2'd0; e_src1 = 32'h0000_0003; e_src2 = 32'h0000_0004;
        @(negedge clk);
        start = 1'b0;
        for (int c = 2; c <= 7; c++) begin
            if (result_valid) begin
                pulses++;
                got = result;
            end
            @(negedge clk);
        end
        checks++;
        if (pulses != 1 || got !== ref_mul(2'd1, 32'hCAFE_F00D, 32'h1357_9BDF)) begin
            errors++;
            $display("FAIL busy_ignore: pulses=%0d result=%h expected 1 %h", pulses, got, ref_mul(2'd1, 32'hCAFE_F00D, 32'h1357_9BDF));
        end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] res;
        int lat, bc;
        start = 1'b1; op = 2'd1; e_src1 = 32'hFFFF_FFFF; e_src2 = 32'hFFFF_FFFF;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midflight_in_p1: busy=%b expected 1", busy);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || result !== 32'd0 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL midflight_reset: busy=%b result=%h rv=%b expected 0 00000000 0", busy, result, result_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midflight_no_pulse: rv=%b busy=%b expected 0 0", result_valid, busy);
        end
        run_op(2'd0, 32'd7, 32'd9, res, lat, bc);
        checks++;
        if (res !== 32'h0000_003F || lat != 2) begin
            errors++;
            $display("FAIL after_reset_mul: got %h lat=%0d expected 0000003f lat=2", res, lat);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [31:0] edges [7] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_FFFF, 32'hFFFF_0000};
        logic [31:0] a, b, res, last;
        logic [1:0]  o;
        int lat, bc, bad;
        bad = 0;
        last = 32'd0;
        for (int i = 0; i < 60; i++) begin
            o = 2'($urandom_range(0, 3));
            a = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 6)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 6)] : $urandom;
            run_op(o, a, b, res, lat, bc);
            checks++;
            if (res !== ref_mul(o, a, b) || lat != exp_lat(o) || bc != exp_lat(o) - 1) begin
                errors++;
                bad++;
                if (bad < 10)
                    $display("FAIL random_%0d op=%0d a=%h b=%h: got %h lat=%0d busy=%0d expected %h lat=%0d",
                             i, o, a, b, res, lat, bc, ref_mul(o, a, b), exp_lat(o));
            end
            last = ref_mul(o, a, b);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (result !== last || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL result_hold: result=%h rv=%b expected %h 0", result, result_valid, last);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_directed();
        test_back_to_back();
        test_busy_ignore();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
